// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch
// Description : Queues ALU requests, issues them in order to an external
//               fixed-latency ALU, and buffers the results for a ready/valid
//               consumer. Issue is credit-gated so the result buffer always
//               has room for every in-flight result.
// Ports       : clk, rst (async, active low)
//               in_valid/in_ready, in_ir, in_a, in_b, in_c, in_imm, in_tag
//               alu_issue, alu_ir, alu_a, alu_b, alu_c, alu_imm, alu_o
//               out_valid/out_ready, out_o, out_tag, busy
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch #(
    parameter int IDEPTH = 4,
    parameter int ODEPTH = 4,
    parameter int LAT    = 1,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [31:0]     in_c,
    input  logic [31:0]     in_imm,
    input  logic [TAGW-1:0] in_tag,
    output logic [31:0]     alu_ir,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [31:0]     alu_c,
    output logic [31:0]     alu_imm,
    output logic            alu_issue,
    input  logic [31:0]     alu_o,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_o,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    localparam int c_iaw = $clog2(IDEPTH);
    localparam int c_icw = c_iaw + 1;
    localparam int c_oaw = $clog2(ODEPTH);
    localparam int c_ocw = c_oaw + 1;
    localparam int c_iew = 160 + TAGW;   // {tag, imm, c, b, a, ir}
    localparam int c_oew = 32 + TAGW;    // {tag, result}

    localparam logic [c_icw-1:0] c_idepth = c_icw'(IDEPTH);
    localparam logic [c_ocw:0]   c_odepth = (c_ocw + 1)'(ODEPTH);

    // ------------------------------------------------------------------
    // Input queue
    // ------------------------------------------------------------------
    logic [c_iew-1:0] r_iq [IDEPTH];
    logic [c_iaw-1:0] r_iwp;
    logic [c_iaw-1:0] r_irp;
    logic [c_icw-1:0] r_icount;
    logic [c_icw-1:0] w_icount_nxt;
    logic             r_in_ready;
    logic [c_iew-1:0] w_head;
    logic             w_accept;
    logic             w_issue;

    // Result side state used by the credit check
    logic [c_ocw-1:0] w_inflight;
    logic [c_ocw-1:0] r_ocount;
    logic [c_ocw:0]   w_credit_used;
    logic             w_cap;
    logic [TAGW-1:0]  w_cap_tag;

    assign w_head        = r_iq[r_irp];
    assign w_accept      = in_valid & r_in_ready;
    assign w_credit_used = {1'b0, w_inflight} + {1'b0, r_ocount};
    // Credit rule: never issue more than the result buffer can absorb.
    assign w_issue       = (r_icount != '0) & (w_credit_used < c_odepth);
    assign in_ready      = r_in_ready;

    always_comb begin
        w_icount_nxt = r_icount;
        if (w_accept && !w_issue) begin
            w_icount_nxt = r_icount + c_icw'(1);
        end else if (!w_accept && w_issue) begin
            w_icount_nxt = r_icount - c_icw'(1);
        end
    end

    // in_ready is a registered compare of the next count, so it is low
    // throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iwp      <= '0;
            r_irp      <= '0;
            r_icount   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_accept) r_iwp <= r_iwp + c_iaw'(1);
            if (w_issue)  r_irp <= r_irp + c_iaw'(1);
            r_icount   <= w_icount_nxt;
            r_in_ready <= (w_icount_nxt < c_idepth);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_iq[r_iwp] <= {in_tag, in_imm, in_c, in_b, in_a, in_ir};
    end

    // ------------------------------------------------------------------
    // ALU port: head entry shown combinationally while issuing, operand
    // values otherwise hold the last issued request.
    // ------------------------------------------------------------------
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [31:0] r_alu_c;
    logic [31:0] r_alu_imm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_c   <= '0;
            r_alu_imm <= '0;
        end else if (w_issue) begin
            r_alu_a   <= w_head[63:32];
            r_alu_b   <= w_head[95:64];
            r_alu_c   <= w_head[127:96];
            r_alu_imm <= w_head[159:128];
        end
    end

    assign alu_issue = w_issue;
    assign alu_ir    = w_issue ? w_head[31:0]    : 32'd0;
    assign alu_a     = w_issue ? w_head[63:32]   : r_alu_a;
    assign alu_b     = w_issue ? w_head[95:64]   : r_alu_b;
    assign alu_c     = w_issue ? w_head[127:96]  : r_alu_c;
    assign alu_imm   = w_issue ? w_head[159:128] : r_alu_imm;

    // ------------------------------------------------------------------
    // Latency tracking: {valid, tag} follows each issue for LAT cycles.
    // ------------------------------------------------------------------
    if (LAT == 0) begin : g_lat0
        assign w_cap      = w_issue;
        assign w_cap_tag  = w_head[c_iew-1:160];
        assign w_inflight = '0;
    end else begin : g_latn
        logic [LAT-1:0]   r_pv;
        logic [TAGW-1:0]  r_pt [LAT];
        logic [c_ocw-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pv  <= '0;
                r_cnt <= '0;
            end else begin
                r_pv[0] <= w_issue;
                for (int i = 1; i < LAT; i++) r_pv[i] <= r_pv[i-1];
                case ({w_issue, w_cap})
                    2'b10:   r_cnt <= r_cnt + c_ocw'(1);
                    2'b01:   r_cnt <= r_cnt - c_ocw'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            r_pt[0] <= w_head[c_iew-1:160];
            for (int i = 1; i < LAT; i++) r_pt[i] <= r_pt[i-1];
        end

        assign w_cap      = r_pv[LAT-1];
        assign w_cap_tag  = r_pt[LAT-1];
        assign w_inflight = r_cnt;
    end

    // ------------------------------------------------------------------
    // Result buffer. Capture never stalls; credits guarantee space.
    // ------------------------------------------------------------------
    logic [c_oew-1:0] r_oq [ODEPTH];
    logic [c_oaw-1:0] r_owp;
    logic [c_oaw-1:0] r_orp;
    logic [c_oew-1:0] w_ohead;
    logic             w_pop;

    assign w_ohead   = r_oq[r_orp];
    assign out_valid = (r_ocount != '0);
    assign w_pop     = out_valid & out_ready;
    assign out_o     = w_ohead[31:0];
    assign out_tag   = w_ohead[c_oew-1:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owp    <= '0;
            r_orp    <= '0;
            r_ocount <= '0;
        end else begin
            if (w_cap) r_owp <= r_owp + c_oaw'(1);
            if (w_pop) r_orp <= r_orp + c_oaw'(1);
            if (w_cap && !w_pop) begin
                r_ocount <= r_ocount + c_ocw'(1);
            end else if (!w_cap && w_pop) begin
                r_ocount <= r_ocount - c_ocw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) r_oq[r_owp] <= {w_cap_tag, alu_o};
    end

    assign busy = (r_icount != '0) | (w_inflight != '0) | (r_ocount != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_dispatch
// Description : Self-checking bench for alu_dispatch. A behavioural ALU with
//               LAT-cycle latency feeds alu_o; a queue scoreboard of expected
//               results (computed at accept time) checks every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_dispatch;

    localparam int IDEPTH = 4;
    localparam int ODEPTH = 4;
    localparam int LAT    = 2;
    localparam int TAGW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir, in_a, in_b, in_c, in_imm;
    logic [TAGW-1:0] in_tag;
    logic [31:0]     alu_ir, alu_a, alu_b, alu_c, alu_imm;
    logic            alu_issue;
    logic [31:0]     alu_o;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_o;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    always #5 clk = ~clk;

    alu_dispatch #(.IDEPTH(IDEPTH), .ODEPTH(ODEPTH), .LAT(LAT), .TAGW(TAGW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imm(in_imm), .in_tag(in_tag),
        .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_imm(alu_imm),
        .alu_issue(alu_issue), .alu_o(alu_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_tag(out_tag),
        .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] ir, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c,
                                           input logic [31:0] imm);
        return (ir ^ (a + b)) - (c ^ {imm[15:0], imm[31:16]});
    endfunction

    // Behavioural ALU: result appears LAT cycles after the issue cycle;
    // garbage is produced in cycles without a live request.
    logic [31:0] hist [8];
    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= alu_issue ? alu_fn(alu_ir, alu_a, alu_b, alu_c, alu_imm) : $urandom;
    end
    assign alu_o = (LAT == 0) ? (alu_issue ? alu_fn(alu_ir, alu_a, alu_b, alu_c, alu_imm) : 32'hdead_beef)
                              : hist[(LAT == 0) ? 0 : LAT-1];

    // Scoreboard: results expected at the output, and results expected at issue.
    logic [31:0]     sb_o [$];
    logic [TAGW-1:0] sb_t [$];
    logic [31:0]     iq_f [$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    bit s_acc, s_pop, s_iss, s_ov;
    bit have_last = 1'b0;
    logic [31:0] last_a, last_b, last_c, last_imm;

    task automatic rand_req(input logic [TAGW-1:0] t);
        in_ir  = $urandom;
        in_a   = $urandom;
        in_b   = $urandom;
        in_c   = $urandom;
        in_imm = $urandom;
        in_tag = t;
    endtask

    // One clock cycle: inputs are already driven in the low phase; sample,
    // check and update the model, then advance to the next low phase.
    task automatic tick();
        logic [31:0] e;
        #1;
        s_acc = in_valid && in_ready;
        s_pop = out_valid && out_ready;
        s_iss = alu_issue;
        s_ov  = out_valid;
        chk("busy", busy, sb_o.size() != 0);
        if (s_iss) begin
            if (iq_f.size() == 0) chk("spurious_issue", 1, 0);
            else chk("issue_data", alu_fn(alu_ir, alu_a, alu_b, alu_c, alu_imm), iq_f.pop_front());
            have_last = 1'b1;
            last_a = alu_a; last_b = alu_b; last_c = alu_c; last_imm = alu_imm;
        end else begin
            chk("idle_alu_ir", alu_ir, 0);
            if (have_last) begin
                chk("hold_a", alu_a, last_a);
                chk("hold_b", alu_b, last_b);
                chk("hold_c", alu_c, last_c);
                chk("hold_imm", alu_imm, last_imm);
            end
        end
        if (s_pop) begin
            if (sb_o.size() == 0) chk("stale_out", 1, 0);
            else begin
                chk("out_o", out_o, sb_o.pop_front());
                chk("out_tag", out_tag, sb_t.pop_front());
            end
        end
        if (s_acc) begin
            e = alu_fn(in_ir, in_a, in_b, in_c, in_imm);
            sb_o.push_back(e);
            sb_t.push_back(in_tag);
            iq_f.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n && sb_o.size() != 0; k++) tick();
        chk("drain_empty", sb_o.size(), 0);
        tick();
    endtask

    int first_iss, first_ov, first_pop, last_pop, pops, acc, iss, tag_n, guard;
    bit seen_full_issue;

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rand_req('0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_issue", alu_issue, 0);
        chk("rst_alu_ir", alu_ir, 0);
        rst = 1'b1;
        #1 chk("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1 chk("ready_after_edge", in_ready, 1);
        @(negedge clk);

        // Single request latency
        first_iss = -1;
        first_ov  = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_req(TAGW'(5));
        for (int k = 0; k < 12; k++) begin
            if (k == 1) in_valid = 1'b0;
            tick();
            if (k == 0) chk("lat_accept", s_acc, 1);
            if (s_iss && first_iss < 0) first_iss = k;
            if (s_ov && first_ov < 0) first_ov = k;
        end
        chk("lat_issue_cycle", first_iss, 1);
        chk("lat_out_cycle", first_ov, LAT + 2);

        // Streaming tags 0..15 with out_ready high
        tag_n = 0; pops = 0; first_pop = -1; last_pop = 0;
        in_valid = 1'b1;
        rand_req('0);
        for (int k = 0; k < 80 && (tag_n < 16 || sb_o.size() != 0); k++) begin
            tick();
            if (s_pop) begin
                if (first_pop < 0) first_pop = k;
                last_pop = k;
                pops++;
            end
            if (s_acc) begin
                tag_n++;
                if (tag_n < 16) rand_req(TAGW'(tag_n));
                else in_valid = 1'b0;
            end
        end
        chk("stream_pops", pops, 16);
        chk("stream_span", last_pop - first_pop, 15);
        drain(20);

        // Output blocked, continuous pushes
        out_ready = 1'b0; in_valid = 1'b1; acc = 0; iss = 0;
        for (int k = 0; k < 20; k++) begin
            rand_req(TAGW'($urandom));
            tick();
            acc += int'(s_acc);
            iss += int'(s_iss);
        end
        chk("sat_issues", iss, ODEPTH);
        chk("sat_accepts", acc, IDEPTH + ODEPTH);
        chk("sat_in_ready", in_ready, 0);

        // Full input queue with an issue in the same cycle accepts nothing
        out_ready = 1'b1; seen_full_issue = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rand_req(TAGW'($urandom));
            tick();
            if (s_iss && !seen_full_issue) begin
                seen_full_issue = 1'b1;
                chk("full_issue_no_accept", s_acc, 0);
            end
        end
        chk("full_issue_seen", seen_full_issue, 1);
        drain(60);

        // Reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; acc = 0; guard = 0;
        while (acc < 5 && guard < 30) begin
            rand_req(TAGW'($urandom));
            tick();
            acc += int'(s_acc);
            guard++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_alu_issue", alu_issue, 0);
        sb_o.delete(); sb_t.delete(); iq_f.delete();
        have_last = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        rand_req(TAGW'(10));
        tick();
        chk("post_rst_accept", s_acc, 1);
        drain(20);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = (k % 200 < 100) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            rand_req(TAGW'($urandom));
            tick();
        end
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
